// File: rtl/bmult_pkg.sv
// Shared constants and FSM state encoding for the 8x8 multiply-accumulate slice.
package bmult_pkg;

  localparam int ACC_W_DEF   = 24;
  localparam int CMP_LAT_DEF = 1;
  localparam int PROD_W      = 16;
  localparam int COMP_W      = 17;
  localparam int CNT_W       = 8;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_e;

endpackage

// File: rtl/bmult8x8_acc_if.sv
// Product-stream input and group-result output handshake bundle.
interface bmult8x8_acc_if
  import bmult_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
);

  logic                     in_valid;
  logic                     in_last;
  logic                     in_ready;
  logic [COMP_W-1:0]        comp_out;
  logic                     acc_valid;
  logic                     acc_ready;
  logic signed [ACC_W-1:0]  acc_data;
  logic [CNT_W-1:0]         acc_cnt;
  logic                     acc_sat;

  modport master (
    output in_valid, in_last, comp_out, acc_ready,
    input  in_ready, acc_valid, acc_data, acc_cnt, acc_sat
  );

  modport slave (
    input  in_valid, in_last, comp_out, acc_ready,
    output in_ready, acc_valid, acc_data, acc_cnt, acc_sat
  );

endinterface

// File: rtl/bmult_vld_dly.sv
// Shift register that carries accepted valid/last flags alongside the compressor latency.
module bmult_vld_dly
  import bmult_pkg::*;
#(
  parameter int STAGES = CMP_LAT_DEF
)(
  input  logic clk,
  input  logic rst,
  input  logic vld_p0,
  input  logic last_p0,
  output logic vld_pn,
  output logic last_pn
);

  logic [STAGES-1:0] vld_sr;
  logic [STAGES-1:0] last_sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_sr  <= '0;
      last_sr <= '0;
    end else begin
      vld_sr[0]  <= vld_p0;
      last_sr[0] <= last_p0;
      for (int i = 1; i < STAGES; i++) begin
        vld_sr[i]  <= vld_sr[i-1];
        last_sr[i] <= last_sr[i-1];
      end
    end
  end

  assign vld_pn  = vld_sr[STAGES-1];
  assign last_pn = last_sr[STAGES-1];

endmodule

// File: rtl/bmult8x8_acc.sv
// Saturating group accumulator for signed 16-bit products from a bit-heap compressor;
// presents one sum/count/sat result per group and blocks new input until it is taken.
module bmult8x8_acc
  import bmult_pkg::*;
#(
  parameter int ACC_W   = ACC_W_DEF,
  parameter int CMP_LAT = CMP_LAT_DEF
)(
  input logic             clk,
  input logic             rst,
  bmult8x8_acc_if.slave   bus
);

  localparam int SUM_W = ACC_W + 1;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  function automatic logic signed [SUM_W-1:0] add_wide(
    input logic signed [ACC_W-1:0]  a,
    input logic signed [PROD_W-1:0] p
  );
    return SUM_W'(a) + SUM_W'(p);
  endfunction

  function automatic logic is_ovf(input logic signed [SUM_W-1:0] w);
    return w[SUM_W-1] ^ w[SUM_W-2];
  endfunction

  function automatic logic signed [ACC_W-1:0] sat_clamp(input logic signed [SUM_W-1:0] w);
    if (!is_ovf(w))
      return w[ACC_W-1:0];
    else if (w[SUM_W-1])
      return ACC_MIN;
    else
      return ACC_MAX;
  endfunction

  acc_state_e               state;
  logic signed [ACC_W-1:0]  sum_q;
  logic [CNT_W-1:0]         cnt_q;
  logic                     sat_q;
  logic                     acc_valid_q;
  logic                     in_ready_q;
  logic                     blk_q;

  logic                     vld_p0;
  logic                     last_p0;
  logic                     vld_p1;
  logic                     last_p1;
  logic signed [PROD_W-1:0] prod_p1;
  logic signed [SUM_W-1:0]  sum_w_p1;
  logic signed [ACC_W-1:0]  sum_sat_p1;
  logic                     ovf_p1;
  logic                     hs;
  logic                     blk_n;
  logic                     unused_comp_msb;

  // Stage p0: accepted input; flags enter the compressor-aligned delay line
  assign vld_p0  = bus.in_valid & in_ready_q;
  assign last_p0 = vld_p0 & bus.in_last;

  bmult_vld_dly #(
    .STAGES (CMP_LAT)
  ) u_vld_dly (
    .clk     (clk),
    .rst     (rst),
    .vld_p0  (vld_p0),
    .last_p0 (last_p0),
    .vld_pn  (vld_p1),
    .last_pn (last_p1)
  );

  // Stage p1: compressor result aligned with its flags; bit 16 is a carry artefact
  assign prod_p1         = bus.comp_out[PROD_W-1:0];
  assign unused_comp_msb = bus.comp_out[COMP_W-1];

  always_comb begin
    sum_w_p1   = add_wide(sum_q, prod_p1);
    sum_sat_p1 = sat_clamp(sum_w_p1);
    ovf_p1     = is_ovf(sum_w_p1);
  end

  assign hs = acc_valid_q & bus.acc_ready;

  always_comb begin
    blk_n = blk_q;
    if (last_p0)
      blk_n = 1'b1;
    else if (hs)
      blk_n = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sum_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      acc_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      blk_q       <= 1'b0;
    end else begin
      blk_q      <= blk_n;
      in_ready_q <= ~blk_n;
      case (state)
        IDLE, ACCUM: begin
          if (vld_p1) begin
            sum_q <= sum_sat_p1;
            cnt_q <= (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
            sat_q <= sat_q | ovf_p1;
            if (last_p1) begin
              state       <= HOLD;
              acc_valid_q <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (hs) begin
            state       <= IDLE;
            acc_valid_q <= 1'b0;
            sum_q       <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          acc_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Stage p2: registered group result
  assign bus.in_ready  = in_ready_q;
  assign bus.acc_valid = acc_valid_q;
  assign bus.acc_data  = sum_q;
  assign bus.acc_cnt   = cnt_q;
  assign bus.acc_sat   = sat_q;

endmodule

// File: tb/tb_bmult8x8_acc.sv
// Directed bench for bmult8x8_acc: single-product table plus multi-cycle group sequences.
module tb_bmult8x8_acc;
  import bmult_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [16:0] cmp_src;
  int          nvec = 0;
  int          nmis = 0;

  always #5 clk = ~clk;

  bmult8x8_acc_if #(.ACC_W(24)) bus();

  bmult8x8_acc #(
    .ACC_W   (24),
    .CMP_LAT (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // One-cycle compressor model: comp_out follows the operands by CMP_LAT=1
  always_ff @(posedge clk) bus.comp_out <= cmp_src;

  typedef struct {
    logic [16:0] comp;
    int          exp_d;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic send_item(input logic [16:0] c, input bit last);
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    cmp_src      = c;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    cmp_src      = '0;
  endtask

  task automatic wait_result(input string nm, input int exp_d, input int exp_c, input int exp_s);
    bit got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = bus.acc_valid;
    end
    chk({nm, " acc_valid"}, int'(got), 1);
    chk({nm, " acc_data"},  int'(bus.acc_data), exp_d);
    chk({nm, " acc_cnt"},   int'(bus.acc_cnt), exp_c);
    chk({nm, " acc_sat"},   int'(bus.acc_sat), exp_s);
    bus.acc_ready = 1'b1;
    @(posedge clk); #1;
    bus.acc_ready = 1'b0;
    @(negedge clk);
    chk({nm, " released"}, int'(bus.acc_valid), 0);
    chk({nm, " in_ready after"}, int'(bus.in_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{17'h00064,  100};
    tbl[1] = '{17'h1FFFF,   -1};
    tbl[2] = '{17'h10005,    5};
    tbl[3] = '{17'h08000, -32768};
    tbl[4] = '{17'h07FFF, 32767};
    tbl[5] = '{17'h00000,    0};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.acc_ready = 1'b0;
    cmp_src       = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset in_ready",  int'(bus.in_ready), 0);
    chk("reset acc_valid", int'(bus.acc_valid), 0);
    chk("reset acc_data",  int'(bus.acc_data), 0);
    chk("reset acc_cnt",   int'(bus.acc_cnt), 0);
    chk("reset acc_sat",   int'(bus.acc_sat), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // single-product groups
    for (int v = 0; v < 6; v++) begin
      send_item(tbl[v].comp, 1'b1);
      @(negedge clk);
      chk($sformatf("tbl%0d in_ready low", v), int'(bus.in_ready), 0);
      chk($sformatf("tbl%0d early valid", v), int'(bus.acc_valid), 0);
      wait_result($sformatf("tbl%0d", v), tbl[v].exp_d, 1, 0);
    end

    // 100, -50, 7 with exact result latency
    send_item(17'h00064, 1'b0);
    send_item(17'h0FFCE, 1'b0);
    send_item(17'h00007, 1'b1);
    @(negedge clk);
    chk("grp3 valid at +1", int'(bus.acc_valid), 0);
    chk("grp3 in_ready low", int'(bus.in_ready), 0);
    @(negedge clk);
    chk("grp3 valid at +2", int'(bus.acc_valid), 1);
    wait_result("grp3", 57, 3, 0);

    // 600 x 16129: sum clamps, count saturates
    for (int i = 0; i < 599; i++) send_item(17'h03F01, 1'b0);
    send_item(17'h03F01, 1'b1);
    wait_result("sat600", 8388607, 255, 1);

    // back-pressure in HOLD with ignored input pulses
    send_item(17'h00009, 1'b0);
    send_item(17'h00002, 1'b1);
    begin
      bit got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        got = bus.acc_valid;
      end
      chk("hold acc_valid", int'(got), 1);
    end
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = c[0] ? 1'b0 : 1'b1;
      bus.in_last  = 1'b1;
      cmp_src      = 17'h00050;
      @(negedge clk);
      chk($sformatf("hold%0d acc_valid", c), int'(bus.acc_valid), 1);
      chk($sformatf("hold%0d acc_data", c),  int'(bus.acc_data), 11);
      chk($sformatf("hold%0d acc_cnt", c),   int'(bus.acc_cnt), 2);
      chk($sformatf("hold%0d acc_sat", c),   int'(bus.acc_sat), 0);
      chk($sformatf("hold%0d in_ready", c),  int'(bus.in_ready), 0);
    end
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    cmp_src       = '0;
    bus.acc_ready = 1'b1;
    @(posedge clk); #1;
    bus.acc_ready = 1'b0;
    @(negedge clk);
    chk("hold consumed", int'(bus.acc_valid), 0);
    chk("hold in_ready back", int'(bus.in_ready), 1);
    send_item(17'h00003, 1'b1);
    wait_result("after hold", 3, 1, 0);

    // reset mid-group, then a fresh group
    send_item(17'h0000A, 1'b0);
    send_item(17'h00014, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst acc_data",  int'(bus.acc_data), 0);
    chk("midrst acc_cnt",   int'(bus.acc_cnt), 0);
    chk("midrst in_ready",  int'(bus.in_ready), 0);
    chk("midrst acc_valid", int'(bus.acc_valid), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst release in_ready", int'(bus.in_ready), 0);
    @(negedge clk);
    chk("rst release +1 in_ready", int'(bus.in_ready), 1);
    send_item(17'h00003, 1'b0);
    send_item(17'h00004, 1'b1);
    wait_result("post rst", 7, 2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/bmult8x8_acc.md
BMULT8X8_ACC -- requirements
Module: bmult8x8_acc

Interface
REQ-001 SHALL have parameter ACC_W, default 24: accumulator width in bits.
REQ-002 SHALL have parameter CMP_LAT, default 1: latency in cycles of the upstream bit-heap compressor from column inputs to comp_out.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset; synchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1: compressor column inputs carry a product operand pair this cycle.
REQ-006 SHALL have port in_last, input, 1: qualified by in_valid; marks the final product of a group.
REQ-007 SHALL have port in_ready, output, 1: block accepts in_valid this cycle.
REQ-008 SHALL have port comp_out, input, 17: compressor result, valid CMP_LAT cycles after the matching in_valid.
REQ-009 SHALL have port acc_valid, output, 1: group result available.
REQ-010 SHALL have port acc_ready, input, 1: downstream accepts the result.
REQ-011 SHALL have port acc_data, output, ACC_W: signed group sum.
REQ-012 SHALL have port acc_cnt, output, 8: products in group, saturating at 255.
REQ-013 SHALL have port acc_sat, output, 1: sum saturated at least once in group.

Function
REQ-014 SHALL accept an input item only when in_valid and in_ready are both 1; in_valid while in_ready=0 is ignored.
REQ-015 SHALL delay the accepted valid/last flags by exactly CMP_LAT cycles to align them with comp_out.
REQ-016 SHALL treat comp_out[15:0] as a signed 16-bit product and ignore comp_out[16].
REQ-017 SHALL sign-extend the product to ACC_W bits and add it to the running sum each aligned-valid cycle.
REQ-018 SHALL clamp the sum to +(2^(ACC_W-1))-1 or -(2^(ACC_W-1)) on overflow and set the group's sticky sat flag.
REQ-019 SHALL use FSM states IDLE (no group open), ACCUM (group open), HOLD (result presented).
REQ-020 SHALL move IDLE->ACCUM on an aligned valid without last, ACCUM->HOLD on an aligned last, and IDLE->HOLD on an aligned valid with last.
REQ-021 SHALL move HOLD->IDLE when acc_valid and acc_ready are both 1, and clear sum, count and sat in the same edge.
REQ-022 SHALL drive in_ready=0 from the cycle after an accepted in_last until the cycle after the HOLD handshake; otherwise 1.
REQ-023 SHALL assert acc_valid one cycle after the aligned last, i.e. CMP_LAT+1 cycles after in_last acceptance.
REQ-024 SHALL hold acc_data, acc_cnt and acc_sat stable while acc_valid=1 and acc_ready=0.
REQ-025 SHALL accept a single-item group (in_valid and in_last together) and report that product with acc_cnt=1.
REQ-026 SHALL increment acc_cnt per aligned valid, holding at 255 without wrapping.

Reset
REQ-027 SHALL, while rst=1, clear FSM to IDLE, zero the sum, count, sat flag and delay line, and drive acc_valid=0, acc_data=0, acc_cnt=0, acc_sat=0, in_ready=0.
REQ-028 SHALL, on rst mid-group or in HOLD, discard all in-flight and presented data; in_ready returns to 1 the cycle after rst deasserts.

Structure
REQ-029 SHALL take ACC_W default, CMP_LAT default and the FSM state enum from shared package bmult_pkg.
REQ-030 SHALL implement the valid/last alignment as sub-module bmult_vld_dly (CMP_LAT-deep shift register with synchronous reset).

Verification
REQ-031 SHALL cover group of products 100, -50, 7 (last on 7) -> acc_data=57, acc_cnt=3, acc_sat=0, acc_valid 2 cycles after last accepted.
REQ-032 SHALL cover 600 products of 16129 (comp_out=0x03F01) -> acc_data=8388607, acc_cnt=255, acc_sat=1.
REQ-033 SHALL cover acc_ready held 0 for 5 cycles in HOLD -> outputs stable, in_ready=0, in_valid pulses ignored; result consumed on the 6th cycle.
REQ-034 SHALL cover a single product with comp_out=0x1FFFF -> acc_data=-1 (0xFFFFFF), acc_cnt=1.
REQ-035 SHALL cover rst pulse after 2 of 4 products, then new group 3, 4 -> acc_data=7, acc_cnt=2.
